// File: rtl/sap1_ram_arbiter.sv
// sap1_ram_arbiter: arbitrates CPU reads and panel writes to the 16x4 RAM and times its n_ce/n_we strobes.
module sap1_ram_arbiter #(
  parameter int unsigned RD_WAIT_CYCLES  = 1,
  parameter int unsigned WR_PULSE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       prog_mode,
  input  logic       prog_req,
  input  logic [3:0] prog_addr,
  input  logic [3:0] prog_data,
  output logic       prog_ack,
  input  logic       cpu_req,
  input  logic [3:0] cpu_addr,
  output logic [3:0] cpu_rdata,
  output logic       cpu_ack,
  output logic       busy,
  output logic [3:0] ram_a,
  output logic [3:0] ram_d,
  output logic       ram_n_ce,
  output logic       ram_n_we,
  input  logic [3:0] ram_q
);
  typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] ram_a_n, ram_d_n, cpu_rdata_n;
  logic ram_n_ce_n, ram_n_we_n, prog_ack_n, cpu_ack_n, busy_n;
  logic wr_go, rd_go, rd_last, wr_last;
  assign wr_go   = prog_mode & prog_req;
  assign rd_go   = ~prog_mode & cpu_req;
  assign rd_last = cnt == 4'(RD_WAIT_CYCLES);
  assign wr_last = cnt == 4'(WR_PULSE_CYCLES - 1);
  always_ff @(posedge clk or negedge n_clr)
    if (!n_clr) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_a     <= '0;
      ram_d     <= '0;
      ram_n_ce  <= 1'b1;
      ram_n_we  <= 1'b1;
      prog_ack  <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ram_a     <= ram_a_n;
      ram_d     <= ram_d_n;
      ram_n_ce  <= ram_n_ce_n;
      ram_n_we  <= ram_n_we_n;
      prog_ack  <= prog_ack_n;
      cpu_ack   <= cpu_ack_n;
      cpu_rdata <= cpu_rdata_n;
      busy      <= busy_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = wr_go ? WR_SETUP : rd_go ? RD_ACC : IDLE;
      RD_ACC:   state_n = rd_last ? IDLE : RD_ACC;
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: state_n = wr_last ? WR_HOLD : WR_PULSE;
      WR_HOLD:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // Outputs are computed from the upcoming state so the strobes are registered without extra lag.
  always_comb begin
    cnt_n       = (state_n == state && state != IDLE) ? cnt + 4'd1 : 4'd0;
    ram_n_ce_n  = state_n == IDLE;
    ram_n_we_n  = state_n != WR_PULSE;
    ram_a_n     = state != IDLE ? ram_a : wr_go ? prog_addr : rd_go ? cpu_addr : ram_a;
    ram_d_n     = (state == IDLE && wr_go) ? prog_data : ram_d;
    prog_ack_n  = state == WR_HOLD;
    cpu_ack_n   = state == RD_ACC && rd_last;
    cpu_rdata_n = cpu_ack_n ? ram_q : cpu_rdata;
    busy_n      = state_n != IDLE;
  end
endmodule

// File: tb/tb_sap1_ram_arbiter.sv
// tb_sap1_ram_arbiter: directed checks of the RAM arbiter with default and stretched strobe timing.
module tb_sap1_ram_arbiter;
  logic clk = 0, n_clr = 0, prog_mode = 0, prog_req = 0, cpu_req = 0;
  logic [3:0] prog_addr = 0, prog_data = 0, cpu_addr = 0;
  logic prog_ack1, cpu_ack1, busy1, n_ce1, n_we1, prog_ack2, cpu_ack2, busy2, n_ce2, n_we2;
  logic [3:0] rdata1, a1, d1, q1, rdata2, a2, d2, q2;
  logic [3:0] mem1 [16];
  logic [3:0] mem2 [16];
  bit sel = 0;
  int vecs = 0, errs = 0;
  wire m_prog_ack = sel ? prog_ack2 : prog_ack1;
  wire m_cpu_ack  = sel ? cpu_ack2 : cpu_ack1;
  wire m_n_ce     = sel ? n_ce2 : n_ce1;
  wire m_n_we     = sel ? n_we2 : n_we1;
  wire [3:0] m_a  = sel ? a2 : a1;
  wire [3:0] m_d  = sel ? d2 : d1;
  wire [3:0] m_rd = sel ? rdata2 : rdata1;
  sap1_ram_arbiter dut (
    .clk(clk), .n_clr(n_clr), .prog_mode(prog_mode), .prog_req(prog_req),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack1),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(rdata1), .cpu_ack(cpu_ack1),
    .busy(busy1), .ram_a(a1), .ram_d(d1), .ram_n_ce(n_ce1), .ram_n_we(n_we1), .ram_q(q1));
  sap1_ram_arbiter #(.RD_WAIT_CYCLES(3), .WR_PULSE_CYCLES(4)) dut2 (
    .clk(clk), .n_clr(n_clr), .prog_mode(prog_mode), .prog_req(prog_req),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack2),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(rdata2), .cpu_ack(cpu_ack2),
    .busy(busy2), .ram_a(a2), .ram_d(d2), .ram_n_ce(n_ce2), .ram_n_we(n_we2), .ram_q(q2));
  always #5 clk = ~clk;
  always @(posedge clk) if (!n_ce1 && !n_we1) mem1[a1] <= d1;
  always @(posedge clk) if (!n_ce2 && !n_we2) mem2[a2] <= d2;
  assign q1 = mem1[a1];
  assign q2 = mem2[a2];
  typedef struct {
    logic wr;
    logic [3:0] a;
    logic [3:0] d;
    int lat;
    int we_low;
    logic [3:0] rd;
  } vec_t;
  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic txn(input logic wr, input logic [3:0] a, input logic [3:0] d,
                     output int lat, output int we_low, output int stable, output logic [3:0] rd);
    logic [3:0] a0, d0;
    @(negedge clk);
    prog_mode = wr;
    if (wr) begin prog_addr = a; prog_data = d; prog_req = 1; end
    else begin cpu_addr = a; cpu_req = 1; end
    @(posedge clk); #1;
    lat = -1; we_low = 0; a0 = m_a; d0 = m_d;
    stable = (a0 == a && m_n_ce == 0) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      if (!m_n_ce && (m_a != a0 || (wr && m_d != d0))) stable = 0;
      if (!m_n_we) begin we_low++; if (m_n_ce) stable = 0; end
      @(posedge clk); #1;
      if (wr ? m_prog_ack : m_cpu_ack) begin lat = k; break; end
    end
    prog_req = 0; cpu_req = 0; rd = m_rd;
  endtask
  initial begin
    vec_t tbl [7];
    int lat, wl, st, n, acks;
    logic [3:0] rd;
    tbl[0] = '{1'b1, 4'h3, 4'hA, 3, 1, 4'h0};
    tbl[1] = '{1'b1, 4'hF, 4'h5, 3, 1, 4'h0};
    tbl[2] = '{1'b0, 4'h3, 4'h0, 2, 0, 4'hA};
    tbl[3] = '{1'b0, 4'hF, 4'h0, 2, 0, 4'h5};
    tbl[4] = '{1'b1, 4'h0, 4'hC, 3, 1, 4'h0};
    tbl[5] = '{1'b0, 4'h0, 4'h0, 2, 0, 4'hC};
    tbl[6] = '{1'b0, 4'hF, 4'h0, 2, 0, 4'h5};
    prog_mode = 1; prog_req = 1; cpu_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_n_ce", int'(n_ce1), 1);
    chk("rst_n_we", int'(n_we1), 1);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_acks", int'(prog_ack1 | cpu_ack1), 0);
    chk("rst_rdata", int'(rdata1), 0);
    chk("rst_ram_a", int'(a1), 0);
    @(negedge clk); n_clr = 1;
    @(posedge clk); #1;
    chk("rst_release_accept", int'(busy1), 1);
    for (n = 0; n < 10 && !prog_ack1; n++) begin @(posedge clk); #1; end
    prog_req = 0; cpu_req = 0;
    chk("rst_first_write_lat", n, 3);
    for (int i = 0; i < 7; i++) begin
      txn(tbl[i].wr, tbl[i].a, tbl[i].d, lat, wl, st, rd);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_stable", i), st, 1);
      if (tbl[i].wr) chk($sformatf("v%0d_we_low", i), wl, tbl[i].we_low);
      else chk($sformatf("v%0d_rdata", i), int'(rd), int'(tbl[i].rd));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ack_one_cycle", i), int'(prog_ack1 | cpu_ack1), 0);
    end
    @(negedge clk);
    prog_mode = 1; prog_req = 1; cpu_req = 1; prog_addr = 7; prog_data = 6; cpu_addr = 7;
    @(posedge clk); @(posedge clk);
    @(negedge clk); prog_mode = 0;
    acks = 0;
    for (n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (cpu_ack1) acks++;
      if (prog_ack1) break;
    end
    prog_req = 0;
    chk("both_write_acked", int'(prog_ack1), 1);
    chk("both_no_cpu_ack", acks, 0);
    for (n = 0; n < 10 && !cpu_ack1; n++) begin @(posedge clk); #1; end
    cpu_req = 0;
    chk("flip_read_lat", n, 3);
    chk("flip_read_data", int'(rdata1), 6);
    @(negedge clk);
    prog_mode = 1; prog_addr = 9; prog_data = 3; prog_req = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("abort_in_pulse", int'(n_we1 | n_ce1), 0);
    #2 n_clr = 0;
    #1;
    chk("abort_n_we", int'(n_we1), 1);
    chk("abort_n_ce", int'(n_ce1), 1);
    chk("abort_busy", int'(busy1), 0);
    prog_req = 0;
    acks = 0;
    repeat (2) begin @(posedge clk); #1; if (prog_ack1) acks++; end
    @(negedge clk); n_clr = 1;
    repeat (4) begin @(posedge clk); #1; if (prog_ack1) acks++; end
    chk("abort_no_ack", acks, 0);
    chk("abort_idle", int'(busy1), 0);
    @(negedge clk); n_clr = 0; sel = 1;
    @(negedge clk); n_clr = 1;
    txn(1'b1, 4'h2, 4'h9, lat, wl, st, rd);
    chk("p_write_lat", lat, 6);
    chk("p_we_low", wl, 4);
    chk("p_write_stable", st, 1);
    @(posedge clk); #1;
    txn(1'b0, 4'h2, 4'h0, lat, wl, st, rd);
    chk("p_read_lat", lat, 4);
    chk("p_read_data", int'(rd), 9);
    chk("p_read_stable", st, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
